seq_shifter: RTL and testbench
==============================

// Module: seq_shifter
// PURPOSE
//  Multi-cycle parametrised shifter, the general successor to the fixed shift-left-by-2 block.
//  Shifts an N-bit operand by a runtime amount in one of four modes (SLL/SRL/SRA/ROL).
//  Moves at most STEP bit positions per clock, trading latency for area.
//  Sits beside the ALU for variable shift instructions; start/busy/done handshake to control.
// PARAMETERS
//  N     32  operand/result width; power of 2, >= 8
//  SHW   $clog2(N)  shift-amount width (derived, do not override)
//  STEP  4   max bit positions shifted per cycle; 1 <= STEP <= N-1
// PORTS
//  clk      in   1    clock, rising edge
//  reset_n  in   1    asynchronous active-low reset
//  start    in   1    request; sampled on rising edge in IDLE or DONE only
//  A        in   N    operand, captured when start accepted
//  SHAMT    in   SHW  shift amount 0..N-1, captured with A
//  MODE     in   2    00 SLL, 01 SRL (zero fill), 10 SRA (sign fill), 11 ROL (rotate left)
//  busy     out  1    high while in SHIFT state
//  done     out  1    one-cycle pulse: Y holds a new valid result
//  Y        out  N    result register; holds last result until next completion
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, Y=0, busy=0, done=0, internal work/count regs=0.
//  States: IDLE, SHIFT, DONE.
//  IDLE: start=1 -> capture A, SHAMT, MODE into work/rem/mode regs;
//        SHAMT==0 -> DONE (Y<=A), else -> SHIFT. start=0 -> stay.
//  SHIFT: each edge shifts work by s=min(rem,STEP) per mode, rem<=rem-s;
//         when rem-s==0 -> DONE and Y<=shifted value same edge. start ignored in SHIFT.
//  DONE: done=1 for exactly this cycle; next edge -> IDLE, or, if start=1, accept new
//        request exactly as IDLE does (back-to-back, no bubble).
//  Latency: k=ceil(SHAMT/STEP) shift cycles; start accepted at edge t0 -> done high in
//    the cycle after edge t0+k (SHAMT=0: cycle after t0).
//  busy=1 iff state==SHIFT; busy and done never both high.
//  SRA fill = captured A[N-1], constant for all steps. ROL wraps MSBs into LSBs.
//  Width: SHAMT < N by construction; no overflow; result is N bits, discarded bits lost (SLL/SRL/SRA).
//  Y changes only on DONE entry or reset; A/SHAMT/MODE changes after capture have no effect.
//  Reset mid-operation: abort immediately, all outputs to reset values, no done pulse.
// TESTING
//  N=32,STEP=4: SLL A=0x00000001 SHAMT=2 -> k=1, done after t0+1, Y=0x00000004.
//  SRA A=0x80000000 SHAMT=31 -> busy 8 cycles, done after t0+8, Y=0xFFFFFFFF;
//    SRL same inputs -> Y=0x00000001.
//  ROL A=0x80000001 SHAMT=4 -> Y=0x00000018 after 1 shift cycle.
//  SHAMT=0, MODE=SRA, A=0xDEADBEEF -> busy never high, done after t0, Y=0xDEADBEEF.
//  start pulsed during SHIFT with new A -> ignored, Y equals first request's result;
//    start held during DONE -> second request accepted with no IDLE cycle.
//  reset_n low mid-SHIFT of SHAMT=31 -> busy=0, done=0, Y=0 at once; no done afterwards
//    until a new start.

Source files
------------

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle variable shifter (SLL/SRL/SRA/ROL).
// Moves the operand by at most STEP bit positions per clock, so a shift by
// SHAMT takes ceil(SHAMT/STEP) cycles in SHIFT. A shift amount of zero goes
// straight to DONE.
//
// Ports
//   clk      in   1    clock, rising edge
//   reset_n  in   1    asynchronous active-low reset
//   start    in   1    request, accepted in IDLE or DONE only
//   A        in   N    operand, captured when start is accepted
//   SHAMT    in   SHW  shift amount 0..N-1, captured with A
//   MODE     in   2    00 SLL, 01 SRL, 10 SRA, 11 ROL
//   busy     out  1    high while in SHIFT
//   done     out  1    one-cycle pulse when Y holds a new result
//   Y        out  N    result register, held until the next completion
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start
// S_SHIFT | moving work by min(rem, STEP) positions per clock
// S_DONE  | Y valid, done pulsed; a start here is accepted with no bubble

module seq_shifter #(
    parameter int N    = 32,
    parameter int SHW  = $clog2(N),
    parameter int STEP = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [SHW-1:0] SHAMT,
    input  logic [1:0]     MODE,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   Y
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] M_SLL = 2'b00;
    localparam logic [1:0] M_SRL = 2'b01;
    localparam logic [1:0] M_SRA = 2'b10;

    localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

    state_t         r_state;
    logic [N-1:0]   r_work;
    logic [SHW-1:0] r_rem;
    logic [1:0]     r_mode;
    logic [N-1:0]   r_y;

    state_t         w_state_nxt;
    logic [N-1:0]   w_work_nxt;
    logic [SHW-1:0] w_rem_nxt;
    logic [1:0]     w_mode_nxt;
    logic [N-1:0]   w_y_nxt;

    logic [SHW-1:0] w_step;
    logic [SHW-1:0] w_rol_back;
    logic [N-1:0]   w_shifted;

    // One step of the datapath. For SRA the running MSB is always the captured
    // sign bit, so an arithmetic shift of work keeps filling with A[N-1].
    // N is a power of two, so -w_step in SHW bits equals N - w_step for the
    // rotate's wrap-around part (and 0 when w_step is 0).
    always_comb begin
        w_step     = (r_rem < STEP_W) ? r_rem : STEP_W;
        w_rol_back = -w_step;
        case (r_mode)
            M_SLL:   w_shifted = r_work << w_step;
            M_SRL:   w_shifted = r_work >> w_step;
            M_SRA:   w_shifted = $unsigned($signed(r_work) >>> w_step);
            default: w_shifted = (r_work << w_step) | (r_work >> w_rol_back);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_rem_nxt   = r_rem;
        w_mode_nxt  = r_mode;
        w_y_nxt     = r_y;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_work_nxt = A;
                    w_rem_nxt  = SHAMT;
                    w_mode_nxt = MODE;
                    if (SHAMT == '0) begin
                        w_state_nxt = S_DONE;
                        w_y_nxt     = A;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                w_work_nxt = w_shifted;
                w_rem_nxt  = r_rem - w_step;
                if (r_rem == w_step) begin
                    w_state_nxt = S_DONE;
                    w_y_nxt     = w_shifted;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_rem   <= '0;
            r_mode  <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_rem   <= w_rem_nxt;
            r_mode  <= w_mode_nxt;
            r_y     <= w_y_nxt;
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign Y    = r_y;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter (N=32, STEP=4).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.

module tb_seq_shifter;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] A;
    logic [4:0]  SHAMT;
    logic [1:0]  MODE;
    logic        busy;
    logic        done;
    logic [31:0] Y;

    int n_chk;
    int n_err;

    seq_shifter #(.N(32), .STEP(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .A       (A),
        .SHAMT   (SHAMT),
        .MODE    (MODE),
        .busy    (busy),
        .done    (done),
        .Y       (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, then follow it to completion. exp_k is the number of
    // cycles busy must stay high before done appears.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] sh,
                          input logic [1:0] md, input logic [31:0] exp_y, input int exp_k);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        A     = a;
        SHAMT = sh;
        MODE  = md;
        @(negedge clk);
        start = 1'b0;
        A     = 32'h5A5A_5A5A;
        SHAMT = 5'd7;
        MODE  = 2'b00;
        cyc   = 0;
        while (!done && cyc < 64) begin
            chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, cyc, exp_k);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_nobusy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_y"}, Y, exp_y);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, "_hold"}, Y, exp_y);
    endtask

    initial begin
        int cyc;
        int seen;
        n_chk   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        A       = '0;
        SHAMT   = '0;
        MODE    = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_y", Y, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("sll2",   32'h0000_0001, 5'd2,  2'b00, 32'h0000_0004, 1);
        run_op("sra31",  32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 8);
        run_op("srl31",  32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 8);
        run_op("rol4",   32'h8000_0001, 5'd4,  2'b11, 32'h0000_0018, 1);
        run_op("sh0",    32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF, 0);
        run_op("rol12",  32'h1234_5678, 5'd12, 2'b11, 32'h4567_8123, 3);
        run_op("srl5",   32'hF000_0000, 5'd5,  2'b01, 32'h0780_0000, 2);
        run_op("sll31",  32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000, 8);
        run_op("sra30p", 32'h4000_0000, 5'd30, 2'b10, 32'h0000_0001, 8);
        run_op("rol31",  32'h0000_0003, 5'd31, 2'b11, 32'h8000_0001, 8);

        // start pulsed mid-SHIFT must be ignored
        @(negedge clk);
        start = 1'b1; A = 32'h8000_0000; SHAMT = 5'd31; MODE = 2'b01;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; A = 32'h1234_5678; SHAMT = 5'd0; MODE = 2'b00;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", {31'b0, busy}, 32'd1);
        cyc = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign_lat", cyc, 32'd6);
        chk("ign_y", Y, 32'h0000_0001);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("ign_nodone", seen, 32'd0);

        // back-to-back: start held into DONE is accepted with no IDLE cycle
        start = 1'b1; A = 32'h0000_0001; SHAMT = 5'd2; MODE = 2'b00;
        @(negedge clk);
        A = 32'h8000_0001; SHAMT = 5'd4; MODE = 2'b11;
        chk("b2b_busy1", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("b2b_done1", {31'b0, done}, 32'd1);
        chk("b2b_y1", Y, 32'h0000_0004);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy2", {31'b0, busy}, 32'd1);
        chk("b2b_nodone", {31'b0, done}, 32'd0);
        @(negedge clk);
        chk("b2b_done2", {31'b0, done}, 32'd1);
        chk("b2b_y2", Y, 32'h0000_0018);
        @(negedge clk);

        // reset in the middle of a long shift
        start = 1'b1; A = 32'h8000_0000; SHAMT = 5'd31; MODE = 2'b10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_done", {31'b0, done}, 32'd0);
        chk("mrst_y", Y, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("mrst_quiet", seen, 32'd0);
        chk("mrst_yhold", Y, 32'd0);

        run_op("post", 32'h0000_00F0, 5'd3, 2'b01, 32'h0000_001E, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
